// File: rtl/design_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : design_1_pkg
//  Description : Shared definitions for the design_1 datapath blocks. Holds the
//                divider FSM state encoding, the default operand width, the
//                bit-counter width and a helper that derives the counter width
//                for any operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package design_1_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Divider FSM encoding, explicit 2-bit width.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter wide enough to count down from 2*DataWidth-1.
    localparam int CNT_W = $clog2(2 * DEFAULT_DATA_WIDTH);

    function automatic int cnt_width(input int data_width);
        return $clog2(2 * data_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/design_1_div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : design_1_div_seq_if
//  Description : Operand/result handshake bundle for design_1_div_seq.
//                master : producer/consumer side (drives operands, out_ready)
//                slave  : divider side (drives in_ready and the result)
//                Signals: in_valid/in_ready, dividend (2*W), divisor (W),
//                         out_valid/out_ready, quotient (2*W), remainder (W),
//                         div_by_zero.
//  Revision    : 1.0  initial release
// ============================================================================
interface design_1_div_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]     remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/design_1_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : design_1_div_step
//  Description : One combinational restoring-division step. Appends the next
//                dividend bit to the partial remainder, compares against the
//                divisor and subtracts when it fits.
//                pr          in   W   partial remainder (always < divisor)
//                dividend_bit in  1   next dividend bit, MSB first
//                divisor     in   W   unsigned divisor
//                pr_next     out  W   updated partial remainder
//                q_bit       out  1   quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module design_1_div_step
    import design_1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic [DATA_WIDTH-1:0] pr,
    input  wire logic                  dividend_bit,
    input  wire logic [DATA_WIDTH-1:0] divisor,
    output logic      [DATA_WIDTH-1:0] pr_next,
    output logic                       q_bit
);

    logic [DATA_WIDTH:0]   w_trial;
    logic [DATA_WIDTH-1:0] w_diff;

    // Trial value is one bit wider than the divisor so the compare never overflows.
    assign w_trial = {pr, dividend_bit};

    // If the top trial bit is set the trial already exceeds any W-bit divisor.
    assign q_bit = w_trial[DATA_WIDTH] | (w_trial[DATA_WIDTH-1:0] >= divisor);

    // The true difference is below the divisor, so modulo-2^W subtraction of
    // the low bits gives the exact result.
    assign w_diff  = w_trial[DATA_WIDTH-1:0] - divisor;
    assign pr_next = q_bit ? w_diff : w_trial[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/design_1_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : design_1_div_seq
//  Description : Iterative restoring divider, one quotient bit per clock.
//                Divides a 2*W-bit unsigned dividend by a W-bit unsigned
//                divisor, producing a 2*W-bit quotient and W-bit remainder.
//                clk  in  1   rising-edge clock
//                rst  in  1   synchronous active-high reset
//                bus  slave modport of design_1_div_seq_if (valid/ready in,
//                     valid/ready out, operands, quotient, remainder,
//                     div_by_zero)
//  Revision    : 1.0  initial release
// ============================================================================
module design_1_div_seq
    import design_1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    design_1_div_seq_if.slave  bus
);

    localparam int                   c_cnt_w    = cnt_width(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(2 * DATA_WIDTH - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [2*DATA_WIDTH-1:0]   r_dvd;     // dividend shift register, MSB is next bit
    logic [DATA_WIDTH-1:0]     r_dvs;
    logic [DATA_WIDTH-1:0]     r_pr;      // partial remainder, final value is the remainder
    logic [2*DATA_WIDTH-1:0]   r_quo;
    logic                      r_dbz;
    logic [DATA_WIDTH-1:0]     w_pr_next;
    logic                      w_q_bit;
    logic                      w_accept;

    design_1_div_step #(
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_step (
        .pr           (r_pr),
        .dividend_bit (r_dvd[2*DATA_WIDTH-1]),
        .divisor      (r_dvs),
        .pr_next      (w_pr_next),
        .q_bit        (w_q_bit)
    );

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register and datapath.
    // A zero divisor makes a single pass through CALC with the counter at 0,
    // so its result appears one clock after acceptance; the result registers
    // are preloaded at accept and held during that pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_pr    <= '0;
            r_quo   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_dvd <= bus.dividend;
                r_dvs <= bus.divisor;
                if (bus.divisor == '0) begin
                    r_cnt <= '0;
                    r_pr  <= bus.dividend[DATA_WIDTH-1:0];
                    r_quo <= '1;
                    r_dbz <= 1'b1;
                end else begin
                    r_cnt <= c_cnt_last;
                    r_pr  <= '0;
                    r_quo <= '0;
                    r_dbz <= 1'b0;
                end
            end else if (r_state == CALC) begin
                if (!r_dbz) begin
                    r_pr  <= w_pr_next;
                    r_quo <= {r_quo[2*DATA_WIDTH-2:0], w_q_bit};
                    r_dvd <= {r_dvd[2*DATA_WIDTH-2:0], 1'b0};
                end
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_pr;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_design_1_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_design_1_div_seq
//  Description : Self-checking bench for design_1_div_seq (DATA_WIDTH=16).
//                Expected results are queued when operands are accepted and
//                compared when the divider presents its result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_design_1_div_seq;

    localparam int DW = 16;

    typedef struct {
        logic [2*DW-1:0] dvd;
        logic [DW-1:0]   dvs;
        logic [2*DW-1:0] q;
        logic [DW-1:0]   r;
        logic            dbz;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    design_1_div_seq_if #(.DATA_WIDTH(DW)) bus ();

    design_1_div_seq #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
        $fatal(1, "watchdog");
    end

    // Present operands, wait for acceptance, queue the expected result.
    // Returns at the falling edge following the accepting edge.
    task automatic send(input logic [2*DW-1:0] dvd, input logic [DW-1:0] dvs,
                        input logic [2*DW-1:0] q, input logic [DW-1:0] r);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        e.dvd = dvd;
        e.dvs = dvs;
        e.q   = q;
        e.r   = r;
        e.dbz = (dvs == '0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // Scramble operands; they must no longer matter.
        bus.dividend = $urandom;
        bus.divisor  = DW'($urandom);
    endtask

    // Wait for the result, compare against the queue head, optionally stall
    // out_ready for hold cycles, then accept. Must be called right after send.
    task automatic collect(input int hold);
        int              n;
        int              exp_lat;
        exp_t            e;
        logic [63:0]     recon;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: result seen with %0d entries, required >0", sb.size());
            return;
        end
        e = sb.pop_front();
        exp_lat = e.dbz ? 1 : 2*DW;
        if (n !== exp_lat || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: %0d clocks (out_valid=%b) required %0d", n, bus.out_valid, exp_lat);
        end
        checks++;
        if (bus.quotient !== e.q) begin
            errors++;
            $display("FAIL quotient: %h/%h got %h required %h", e.dvd, e.dvs, bus.quotient, e.q);
        end
        checks++;
        if (bus.remainder !== e.r) begin
            errors++;
            $display("FAIL remainder: %h/%h got %h required %h", e.dvd, e.dvs, bus.remainder, e.r);
        end
        checks++;
        if (bus.div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL div_by_zero: got %b required %b", bus.div_by_zero, e.dbz);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_in_ready: got %b required 0", bus.in_ready);
        end
        if (!e.dbz) begin
            recon = 64'(bus.quotient) * 64'(e.dvs) + 64'(bus.remainder);
            checks++;
            if (recon !== 64'(e.dvd) || bus.remainder >= e.dvs) begin
                errors++;
                $display("FAIL invariant: q*d+r=%h rem=%h required %h with rem<%h",
                         recon, bus.remainder, e.dvd, e.dvs);
            end
        end
        // Back-pressure: result held, new operands ignored.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'h0000_00FF;
            bus.divisor  = 16'h0003;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b ir=%b q=%h r=%h z=%b required ov=1 ir=0 q=%h r=%h z=%b",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder,
                         bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: out_valid=%b in_ready=%b required 0 and 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1 and 0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: q=%h r=%h z=%b required 0 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_directed();
        send(32'h0000_00C8, 16'h0005, 32'h0000_0028, 16'h0000);
        collect(0);
        send(32'h0006_1D78, 16'h0056, 32'h0000_1234, 16'h0000);
        collect(0);
        send(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000);
        collect(0);
        send(32'h0000_0064, 16'h0007, 32'd14, 16'd2);
        collect(0);
        send(32'h0000_0000, 16'h0001, 32'h0000_0000, 16'h0000);
        collect(0);
        send(32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000);
        collect(0);
    endtask

    task automatic test_div_zero();
        send(32'h0000_1234, 16'h0000, 32'hFFFF_FFFF, 16'h1234);
        collect(0);
    endtask

    task automatic test_backpressure();
        send(32'h0001_0000, 16'h0003, 32'h0000_5555, 16'h0001);
        collect(5);
        // The operands offered during the stall must not have started a job.
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_input: out_valid=%b in_ready=%b required 0 and 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        send(32'h1234_5678, 16'h0021, 32'h0000_0000, 16'h0000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.quotient !== '0 || bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ir=%b ov=%b q=%h r=%h z=%b required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        send(32'h0000_0064, 16'h0007, 32'd14, 16'd2);
        collect(0);
    endtask

    task automatic test_random();
        logic [2*DW-1:0] dvd;
        logic [DW-1:0]   dvs;
        for (int i = 0; i < 1000; i++) begin
            dvd = $urandom;
            if (i % 50 == 7)      dvs = '0;
            else if (i % 4 == 0)  dvs = DW'($urandom_range(1, 15));
            else                  dvs = DW'($urandom);
            if (dvs == '0)
                send(dvd, dvs, '1, dvd[DW-1:0]);
            else
                send(dvd, dvs, dvd / 32'(dvs), DW'(dvd % 32'(dvs)));
            collect(0);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
